// File: rtl/serdesphy_power_sequencer.sv
// rtl/serdesphy_power_sequencer.sv - SerDes PHY analog bring-up/teardown sequencer
// PLL reset/lock, TX enable, CDR reset/lock, lock-loss supervision and sticky faults.
module serdesphy_power_sequencer #(
  parameter int RST_CYCLES  = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int PLL_TIMEOUT = 4096,
  parameter int CDR_TIMEOUT = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_phy_en,
  input  logic       cfg_tx_en,
  input  logic       cfg_rx_en,
  input  logic       cfg_write_strobe,
  input  logic [7:0] cfg_write_addr,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  output logic       pll_en,
  output logic       pll_rst_n,
  output logic       tx_en,
  output logic       rx_en,
  output logic       cdr_en,
  output logic       cdr_rst_n,
  output logic       phy_ready,
  output logic [2:0] seq_state,
  output logic       fault_pll_to,
  output logic       fault_cdr_to,
  output logic       lock_lost
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    PLL_RST  = 3'd1,
    PLL_WAIT = 3'd2,
    TX_UP    = 3'd3,
    RX_RST   = 3'd4,
    CDR_WAIT = 3'd5,
    READY    = 3'd6,
    FAULT    = 3'd7
  } state_t;

  localparam int M1   = (RST_CYCLES > SETTLE_CYC) ? RST_CYCLES : SETTLE_CYC;
  localparam int M2   = (PLL_TIMEOUT > CDR_TIMEOUT) ? PLL_TIMEOUT : CDR_TIMEOUT;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          restart;
  logic [1:0]    pll_sync, cdr_sync;
  logic          pll_lock_s, cdr_lock_s;
  logic          set_pll_to, set_cdr_to, set_lost;
  logic          reconf_pll, reconf_cdr;
  logic          pll_en_nx, pll_rst_n_nx, tx_en_nx, rx_en_nx, cdr_en_nx, cdr_rst_n_nx, phy_ready_nx;

  assign pll_lock_s = pll_sync[1];
  assign cdr_lock_s = cdr_sync[1];
  assign seq_state  = state;
  assign reconf_pll = cfg_write_strobe && (cfg_write_addr == 8'h04);
  assign reconf_cdr = cfg_write_strobe && (cfg_write_addr == 8'h05);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      cnt      <= '0;
      pll_sync <= 2'b00;
      cdr_sync <= 2'b00;
    end else begin
      state    <= state_nx;
      pll_sync <= {pll_sync[0], pll_lock};
      cdr_sync <= {cdr_sync[0], cdr_lock};
      // Counter restarts on any entry, including re-entry of the same state by reconfig.
      if (restart || (state_nx != state)) cnt <= '0;
      else if (cnt != CW'(CMAX))          cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    restart    = 1'b0;
    set_pll_to = 1'b0;
    set_cdr_to = 1'b0;
    set_lost   = 1'b0;
    if (!cfg_phy_en) begin
      state_nx = OFF;
    end else if (state == OFF) begin
      state_nx = PLL_RST;
    end else if (state != FAULT && reconf_pll) begin
      state_nx = PLL_RST;
      restart  = 1'b1;
    end else if ((state == RX_RST || state == CDR_WAIT || state == READY) && reconf_cdr) begin
      state_nx = RX_RST;
      restart  = 1'b1;
    end else begin
      case (state)
        PLL_RST:  if (cnt == CW'(RST_CYCLES - 1)) state_nx = PLL_WAIT;
        PLL_WAIT: begin
          if (pll_lock_s) state_nx = TX_UP;
          else if (cnt == CW'(PLL_TIMEOUT - 1)) begin
            state_nx   = FAULT;
            set_pll_to = 1'b1;
          end
        end
        TX_UP:    if (cnt == CW'(SETTLE_CYC - 1)) state_nx = cfg_rx_en ? RX_RST : READY;
        RX_RST:   if (cnt == CW'(RST_CYCLES - 1)) state_nx = CDR_WAIT;
        CDR_WAIT: begin
          if (cdr_lock_s) state_nx = READY;
          else if (cnt == CW'(CDR_TIMEOUT - 1)) begin
            state_nx   = FAULT;
            set_cdr_to = 1'b1;
          end
        end
        READY: begin
          if (!pll_lock_s) begin
            state_nx = PLL_RST;
            set_lost = 1'b1;
          end else if (rx_en && !cdr_lock_s) begin
            state_nx = RX_RST;
            set_lost = 1'b1;
          end else if (cfg_rx_en && !rx_en) begin
            state_nx = RX_RST;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with the state.
  always_comb begin
    pll_en_nx    = 1'b0;
    pll_rst_n_nx = 1'b0;
    tx_en_nx     = 1'b0;
    rx_en_nx     = 1'b0;
    cdr_en_nx    = 1'b0;
    cdr_rst_n_nx = 1'b0;
    phy_ready_nx = 1'b0;
    case (state_nx)
      PLL_RST:  pll_en_nx = 1'b1;
      PLL_WAIT: {pll_en_nx, pll_rst_n_nx} = 2'b11;
      TX_UP:    {pll_en_nx, pll_rst_n_nx, tx_en_nx} = {2'b11, cfg_tx_en};
      RX_RST:   {pll_en_nx, pll_rst_n_nx, tx_en_nx, rx_en_nx, cdr_en_nx} = {2'b11, cfg_tx_en, 2'b11};
      CDR_WAIT: {pll_en_nx, pll_rst_n_nx, tx_en_nx, rx_en_nx, cdr_en_nx, cdr_rst_n_nx} =
                {2'b11, cfg_tx_en, 3'b111};
      READY: begin
        {pll_en_nx, pll_rst_n_nx, tx_en_nx} = {2'b11, cfg_tx_en};
        {rx_en_nx, cdr_en_nx, cdr_rst_n_nx} = {3{cfg_rx_en}};
        phy_ready_nx = 1'b1;
      end
      default: pll_en_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_en       <= 1'b0;
      pll_rst_n    <= 1'b0;
      tx_en        <= 1'b0;
      rx_en        <= 1'b0;
      cdr_en       <= 1'b0;
      cdr_rst_n    <= 1'b0;
      phy_ready    <= 1'b0;
      fault_pll_to <= 1'b0;
      fault_cdr_to <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      pll_en    <= pll_en_nx;
      pll_rst_n <= pll_rst_n_nx;
      tx_en     <= tx_en_nx;
      rx_en     <= rx_en_nx;
      cdr_en    <= cdr_en_nx;
      cdr_rst_n <= cdr_rst_n_nx;
      phy_ready <= phy_ready_nx;
      if (state_nx == OFF) begin
        fault_pll_to <= 1'b0;
        fault_cdr_to <= 1'b0;
        lock_lost    <= 1'b0;
      end else begin
        fault_pll_to <= fault_pll_to | set_pll_to;
        fault_cdr_to <= fault_cdr_to | set_cdr_to;
        lock_lost    <= lock_lost | set_lost;
      end
    end
  end

endmodule
